pwm_hbridge_dt: RTL and testbench

//  Parametrised signed-duty PWM for one H-bridge (CH_A forward, CH_B reverse).

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_dead_timer.sv | 34 +++
 rtl/pwm_hbridge_dt.sv | 119 +++++++++++
 tb/tb_pwm_hbridge_dt.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the signed-duty H-bridge PWM.
package pwm_pkg;

    localparam int CNT_W_DEF    = 13;
    localparam int DEAD_CYC_DEF = 32;
    localparam int DEAD_W_DEF   = 6;

    typedef enum logic [2:0] {
        IDLE,
        DRV_A,
        DRV_B,
        DEAD,
        BRAKE
    } pwm_st_t;

    // Most-negative input maps to 2**(W-1), which still fits unsigned.
    function automatic logic [31:0] mag_of(input logic signed [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/pwm_dead_timer.sv
// Dead-time counter: after start, done pulses on the DEAD_CYC-th cycle.
module pwm_dead_timer #(
    parameter int DEAD_CYC = 32,
    parameter int DEAD_W   = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam logic [DEAD_W-1:0] LAST = DEAD_W'(DEAD_CYC - 1);

    logic [DEAD_W-1:0] dead_cnt;
    logic              busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            dead_cnt <= '0;
            busy     <= 1'b0;
        end else if (start) begin
            dead_cnt <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            if (dead_cnt == LAST)
                busy <= 1'b0;
            else
                dead_cnt <= dead_cnt + DEAD_W'(1);
        end
    end

    assign done = busy && (dead_cnt == LAST);

endmodule

// File: rtl/pwm_hbridge_dt.sv
// Signed-duty H-bridge PWM with period-aligned duty update,
// dead time on direction change / brake release, and brake mode.
module pwm_hbridge_dt
    import pwm_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter int DEAD_W   = DEAD_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrt_duty,
    input  logic signed [CNT_W:0] duty,
    input  logic               brake,
    output logic               CH_A,
    output logic               CH_B,
    output logic               period_strt,
    output logic               upd_pend
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]      cnt;
    logic signed [CNT_W:0] shadow;
    logic signed [CNT_W:0] active;
    logic signed [CNT_W:0] act_eff;
    logic [31:0]           mag;
    logic                  cnt_zero;
    logic                  on;
    logic                  neg;
    logic                  pos;
    logic                  dead_start;
    logic                  dead_done;
    logic                  drv_a;
    logic                  drv_b;
    pwm_st_t               st;
    pwm_st_t               st_nxt;
    pwm_st_t               st_sgn;

    // The value loaded at cnt==0 governs that very cycle's decision.
    assign cnt_zero = (cnt == '0);
    assign act_eff  = cnt_zero ? shadow : active;
    assign mag      = mag_of(32'(act_eff));
    assign on       = (32'(cnt) < mag);
    assign neg      = act_eff[CNT_W];
    assign pos      = !neg && (act_eff != '0);
    assign st_sgn   = pos ? DRV_A : (neg ? DRV_B : IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            shadow      <= '0;
            active      <= '0;
            upd_pend    <= 1'b0;
            period_strt <= 1'b0;
        end else begin
            cnt         <= cnt + CNT_W'(1);
            period_strt <= (cnt == CNT_MAX);
            if (cnt_zero)
                active <= shadow;
            if (wrt_duty) begin
                shadow   <= duty;
                upd_pend <= 1'b1;
            end else if (cnt_zero) begin
                upd_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        st_nxt     = st;
        dead_start = 1'b0;
        drv_a      = 1'b0;
        drv_b      = 1'b0;
        if (brake) begin
            st_nxt = BRAKE;
        end else begin
            unique case (st)
                IDLE:  if (cnt_zero) st_nxt = st_sgn;
                DRV_A: if (cnt_zero && !pos) st_nxt = neg ? DEAD : IDLE;
                DRV_B: if (cnt_zero && !neg) st_nxt = pos ? DEAD : IDLE;
                DEAD:  if (dead_done) st_nxt = st_sgn;
                BRAKE: st_nxt = DEAD;
                default: st_nxt = IDLE;
            endcase
            dead_start = (st_nxt == DEAD) && (st != DEAD);
        end
        if (st_nxt == BRAKE) begin
            drv_a = 1'b1;
            drv_b = 1'b1;
        end else begin
            drv_a = (st_nxt == DRV_A) && on;
            drv_b = (st_nxt == DRV_B) && on;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            CH_A <= 1'b0;
            CH_B <= 1'b0;
        end else begin
            st   <= st_nxt;
            CH_A <= drv_a;
            CH_B <= drv_b;
        end
    end

    pwm_dead_timer #(
        .DEAD_CYC(DEAD_CYC),
        .DEAD_W  (DEAD_W)
    ) u_dead (
        .clk  (clk),
        .rst  (rst),
        .start(dead_start),
        .done (dead_done)
    );

endmodule

// File: tb/tb_pwm_hbridge_dt.sv
// Directed + randomized bench for pwm_hbridge_dt against a direction/dead-time model.
module tb_pwm_hbridge_dt;

    localparam int CW   = 9;
    localparam int DW   = CW + 1;
    localparam int PER  = 1 << CW;
    localparam int DC   = 32;
    localparam int MAXP = PER - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wrt_duty = 1'b0;
    logic signed [DW-1:0] duty = '0;
    logic                 brake = 1'b0;
    logic                 CH_A;
    logic                 CH_B;
    logic                 period_strt;
    logic                 upd_pend;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    int m_cnt, m_shadow, m_active, m_dir, m_dead;
    bit m_res, m_brk;
    bit e_a, e_b, e_ps, e_up;

    pwm_hbridge_dt #(
        .CNT_W   (CW),
        .DEAD_CYC(DC),
        .DEAD_W  (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wrt_duty   (wrt_duty),
        .duty       (duty),
        .brake      (brake),
        .CH_A       (CH_A),
        .CH_B       (CH_B),
        .period_strt(period_strt),
        .upd_pend   (upd_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0b exp=%0b", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input bit w, input int d, input bit b, input bit r);
        int eff, mag, sg;
        bit a, bb;
        if (r) begin
            m_cnt = 0; m_shadow = 0; m_active = 0; m_dir = 0;
            m_dead = 0; m_res = 0; m_brk = 0;
            e_a = 0; e_b = 0; e_ps = 0; e_up = 0;
            return;
        end
        eff = (m_cnt == 0) ? m_shadow : m_active;
        mag = (eff < 0) ? -eff : eff;
        sg  = (eff > 0) ? 1 : ((eff < 0) ? -1 : 0);
        a = 0;
        bb = 0;
        if (b) begin
            m_brk = 1; m_dead = 0; m_res = 0; m_dir = 0;
            a = 1; bb = 1;
        end else if (m_brk) begin
            m_brk = 0;
            m_dead = DC - 1;
            m_res = (m_dead == 0);
        end else if (m_dead > 0) begin
            m_dead--;
            m_res = (m_dead == 0);
        end else if (m_res || m_cnt == 0) begin
            if (!m_res && m_dir != 0 && sg == -m_dir) begin
                m_dir = 0;
                m_dead = DC - 1;
                m_res = (m_dead == 0);
            end else begin
                m_res = 0;
                m_dir = sg;
                a  = (sg > 0) && (m_cnt < mag);
                bb = (sg < 0) && (m_cnt < mag);
            end
        end else begin
            a  = (m_dir > 0) && (m_cnt < mag);
            bb = (m_dir < 0) && (m_cnt < mag);
        end
        e_up = w ? 1'b1 : ((m_cnt == 0) ? 1'b0 : e_up);
        e_ps = (m_cnt == MAXP);
        if (m_cnt == 0) m_active = m_shadow;
        if (w) m_shadow = d;
        m_cnt = (m_cnt + 1) % PER;
        e_a = a;
        e_b = bb;
    endtask

    task automatic cyc(input bit w, input int d, input bit b, input bit r);
        wrt_duty = w;
        duty     = DW'(d);
        brake    = b;
        rst      = r;
        model_step(w, d, b, r);
        @(posedge clk);
        #1;
        check("ch_a", CH_A, e_a);
        check("ch_b", CH_B, e_b);
        check("period_strt", period_strt, e_ps);
        check("upd_pend", upd_pend, e_up);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic run_to(input int c);
        while (m_cnt != c) cyc(0, 0, 0, 0);
    endtask

    int  sel;
    int  rd;
    bit  brk_lvl;

    initial begin
        // reset
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        idle(3);
        // +100 written mid-period, applied next period
        run_to(50);
        cyc(1, 100, 0, 0);
        idle(2 * PER);
        // reverse to -200 through dead time
        run_to(300);
        cyc(1, -200, 0, 0);
        idle(2 * PER);
        // zero, max positive, most negative
        cyc(1, 0, 0, 0);
        idle(PER + 20);
        cyc(1, MAXP, 0, 0);
        idle(2 * PER);
        cyc(1, -PER, 0, 0);
        idle(2 * PER);
        // brake pulse mid-period
        run_to(150);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0);
        idle(PER);
        // last write wins; write at cnt==0 lands one period later
        run_to(10);
        cyc(1, 10, 0, 0);
        run_to(20);
        cyc(1, 20, 0, 0);
        idle(PER);
        run_to(0);
        cyc(1, 30, 0, 0);
        idle(2 * PER);
        // reset while driving B, then during dead time
        cyc(1, -200, 0, 0);
        idle(PER + 200);
        run_to(60);
        cyc(0, 0, 0, 1);
        idle(PER + 10);
        cyc(1, -100, 0, 0);
        idle(PER + 5);
        cyc(1, 100, 0, 0);
        run_to(10);
        cyc(0, 0, 0, 1);
        idle(PER + 10);
        // randomized traffic
        brk_lvl = 0;
        for (int i = 0; i < 25000; i++) begin
            if (brk_lvl) brk_lvl = ($urandom_range(0, 39) != 0);
            else brk_lvl = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 199) == 0) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: rd = 0;
                    1: rd = MAXP;
                    2: rd = -PER;
                    3: rd = -MAXP;
                    default: rd = int'($urandom_range(0, 2 * PER - 1)) - PER;
                endcase
                cyc(1, rd, brk_lvl, ($urandom_range(0, 3999) == 0));
            end else begin
                cyc(0, 0, brk_lvl, ($urandom_range(0, 3999) == 0));
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
